pipeline_stage_reg: RTL and testbench

//  Generic parametrised inter-stage pipeline register with ready/valid handshake,

---
 rtl/pipeline_stage_reg_pkg.sv | 16 +
 rtl/pipeline_stage_reg_slot.sv | 39 +++
 rtl/pipeline_stage_reg.sv | 121 ++++++++++++
 tb/tb_pipeline_stage_reg.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stage_reg_pkg.sv
// Shared encodings for the inter-stage pipeline register: occupancy/FSM states
// and the bit positions of the common control-bundle fields.
package pipeline_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  localparam int CB_REGWRITE = 0;
  localparam int CB_MEMTOREG = 1;
  localparam int CB_WREN     = 2;
  localparam int CB_RDEN     = 3;

endpackage

// File: rtl/pipeline_stage_reg_slot.sv
// One pipeline entry {valid, ctrl, data}. Clear drops valid/ctrl and wins over
// load; clear_data independently zeroes the payload.
module pipeline_stage_reg_slot #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_clear_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_ctrl  <= '0;
      o_data  <= '0;
    end else begin
      if (i_clear) begin
        o_valid <= 1'b0;
        o_ctrl  <= '0;
      end else if (i_load) begin
        o_valid <= 1'b1;
        o_ctrl  <= i_ctrl;
      end
      if (i_clear_data)
        o_data <= '0;
      else if (i_load && !i_clear)
        o_data <= i_data;
    end
  end

endmodule

// File: rtl/pipeline_stage_reg.sv
// Ready/valid inter-stage register with optional 2-entry skid, synchronous flush
// and control gating so a bubble never carries live control bits downstream.
module pipeline_stage_reg
  import pipeline_stage_reg_pkg::*;
#(
  parameter int CTRL_W     = 16,
  parameter int DATA_W     = 128,
  parameter int SKID       = 1,
  parameter int FLUSH_DATA = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [CTRL_W-1:0] i_in_ctrl,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [CTRL_W-1:0] o_out_ctrl,
  output logic [DATA_W-1:0] o_out_data,
  output logic [1:0]        o_occupancy
);

  occ_e              r_state, w_nxt;
  logic              w_acc, w_emit, w_clr_data;
  logic              w_main_load, w_main_clr, w_skid_load, w_skid_clr;
  logic              w_main_valid, w_skid_valid;
  logic [CTRL_W-1:0] w_main_ctrl, w_skid_ctrl, w_main_ctrl_in;
  logic [DATA_W-1:0] w_main_data, w_skid_data, w_main_data_in;

  assign w_acc      = i_in_valid & o_in_ready;
  assign w_emit     = w_main_valid & i_out_ready;
  assign w_clr_data = i_flush && (FLUSH_DATA != 0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_EMPTY;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt       = r_state;
    w_main_load = 1'b0;
    w_main_clr  = i_flush;
    w_skid_load = 1'b0;
    w_skid_clr  = i_flush;
    if (SKID != 0) begin
      case (r_state)
        ST_EMPTY: if (w_acc) begin
          w_nxt       = ST_ONE;
          w_main_load = 1'b1;
        end
        ST_ONE: begin
          if (w_acc && w_emit) begin
            w_main_load = 1'b1;
          end else if (w_acc) begin
            w_nxt       = ST_TWO;
            w_skid_load = 1'b1;
          end else if (w_emit) begin
            w_nxt      = ST_EMPTY;
            w_main_clr = 1'b1;
          end
        end
        ST_TWO: if (w_emit) begin
          w_nxt       = ST_ONE;
          w_main_load = 1'b1;
          w_skid_clr  = 1'b1;
        end
        default: w_nxt = ST_EMPTY;
      endcase
    end else begin
      if (w_acc) begin
        w_nxt       = ST_ONE;
        w_main_load = 1'b1;
      end else if (w_emit) begin
        w_nxt      = ST_EMPTY;
        w_main_clr = 1'b1;
      end
    end
    if (i_flush) w_nxt = ST_EMPTY;
  end

  // A held skid entry is always older than the input, so it refills main first.
  assign w_main_ctrl_in = w_skid_valid ? w_skid_ctrl : i_in_ctrl;
  assign w_main_data_in = w_skid_valid ? w_skid_data : i_in_data;

  pipeline_stage_reg_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_load(w_main_load), .i_clear(w_main_clr), .i_clear_data(w_clr_data),
    .i_ctrl(w_main_ctrl_in), .i_data(w_main_data_in),
    .o_valid(w_main_valid), .o_ctrl(w_main_ctrl), .o_data(w_main_data)
  );

  if (SKID != 0) begin : g_skid
    logic r_in_ready;

    pipeline_stage_reg_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_load(w_skid_load), .i_clear(w_skid_clr), .i_clear_data(w_clr_data),
      .i_ctrl(i_in_ctrl), .i_data(i_in_data),
      .o_valid(w_skid_valid), .o_ctrl(w_skid_ctrl), .o_data(w_skid_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_in_ready <= 1'b0;
      else          r_in_ready <= (w_nxt != ST_TWO);
    end
    assign o_in_ready = r_in_ready;
  end else begin : g_noskid
    assign w_skid_valid = 1'b0;
    assign w_skid_ctrl  = '0;
    assign w_skid_data  = '0;
    assign o_in_ready   = !w_main_valid | i_out_ready;
  end

  assign o_out_valid = w_main_valid;
  assign o_out_ctrl  = w_main_ctrl & {CTRL_W{w_main_valid}};
  assign o_out_data  = w_main_data;
  assign o_occupancy = r_state;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Directed bench: SKID=1/FLUSH_DATA=0 instance (a_*) and SKID=0/FLUSH_DATA=1 instance (b_*).
module tb_pipeline_stage_reg;
  import pipeline_stage_reg_pkg::*;

  localparam int CW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_occ;
  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_occ;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .FLUSH_DATA(0)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(a_flush),
    .i_in_valid(a_in_valid), .o_in_ready(a_in_ready),
    .i_in_ctrl(a_in_ctrl), .i_in_data(a_in_data),
    .o_out_valid(a_out_valid), .i_out_ready(a_out_ready),
    .o_out_ctrl(a_out_ctrl), .o_out_data(a_out_data), .o_occupancy(a_occ)
  );

  pipeline_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .FLUSH_DATA(1)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(b_flush),
    .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
    .i_in_ctrl(b_in_ctrl), .i_in_data(b_in_data),
    .o_out_valid(b_out_valid), .i_out_ready(b_out_ready),
    .o_out_ctrl(b_out_ctrl), .o_out_data(b_out_data), .o_occupancy(b_occ)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_state(input string tag, input logic v, input logic [31:0] d,
                         input logic [15:0] c, input logic [1:0] o, input logic r);
    chk({tag, ".valid"}, 32'(a_out_valid), 32'(v));
    if (v) chk({tag, ".data"}, a_out_data, d);
    chk({tag, ".ctrl"}, 32'(a_out_ctrl), 32'(c));
    chk({tag, ".occ"}, 32'(a_occ), 32'(o));
    chk({tag, ".rdy"}, 32'(a_in_ready), 32'(r));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] c_ab;
    c_ab = (16'(1) << CB_REGWRITE) | (16'(1) << CB_WREN);

    // reset held with input active
    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 1; a_in_ctrl = 16'hFFFF; a_in_data = 32'hDEAD; a_out_ready = 1;
    b_flush = 0; b_in_valid = 1; b_in_ctrl = 16'hFFFF; b_in_data = 32'hDEAD; b_out_ready = 1;
    repeat (3) step();
    chk("rst.a_valid", 32'(a_out_valid), 0);
    chk("rst.a_ctrl", 32'(a_out_ctrl), 0);
    chk("rst.a_data", a_out_data, 0);
    chk("rst.a_occ", 32'(a_occ), 0);
    chk("rst.b_valid", 32'(b_out_valid), 0);
    chk("rst.b_occ", 32'(b_occ), 0);
    a_in_valid = 0; b_in_valid = 0;
    rst_n = 1'b1;
    step();
    chk("rst.a_rdy", 32'(a_in_ready), 1);
    chk("rst.b_rdy", 32'(b_in_ready), 1);

    // streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1; a_in_data = 32'(i); a_in_ctrl = 16'h00FF;
      step();
      a_state($sformatf("strm%0d", i), 1, 32'(i), 16'h00FF, 2'd1, 1);
    end
    a_in_valid = 0; a_in_ctrl = 16'h0000;
    step();
    a_state("strm.drain", 0, 0, 16'h0, 2'd0, 1);

    // stall / skid: A,B fill, C waits upstream
    a_out_ready = 0; a_in_valid = 1; a_in_ctrl = c_ab; a_in_data = 32'hA;
    step();
    a_state("stall.A", 1, 32'hA, c_ab, 2'd1, 1);
    a_in_data = 32'hB;
    step();
    a_state("stall.B", 1, 32'hA, c_ab, 2'd2, 0);
    a_in_data = 32'hC;
    step();
    a_state("stall.C1", 1, 32'hA, c_ab, 2'd2, 0);
    step();
    a_state("stall.C2", 1, 32'hA, c_ab, 2'd2, 0);
    a_out_ready = 1;
    step();
    a_state("skid.outB", 1, 32'hB, c_ab, 2'd1, 1);
    step();
    a_state("skid.outC", 1, 32'hC, c_ab, 2'd1, 1);
    a_in_valid = 0;
    step();
    a_state("skid.empty", 0, 0, 16'h0, 2'd0, 1);

    // flush in TWO with a concurrent accept attempt
    a_out_ready = 0; a_in_valid = 1; a_in_ctrl = 16'h000F; a_in_data = 32'hD;
    step();
    a_in_data = 32'hE;
    step();
    a_state("fl.two", 1, 32'hD, 16'h000F, 2'd2, 0);
    a_flush = 1; a_out_ready = 1; a_in_data = 32'hF;
    step();
    a_flush = 0; a_in_valid = 0;
    a_state("fl.after", 0, 0, 16'h0, 2'd0, 1);
    chk("fl.data_kept", a_out_data, 32'hD);
    step();
    a_state("fl.noemit", 0, 0, 16'h0, 2'd0, 1);

    // bubbles with live-looking ctrl
    a_in_valid = 0; a_in_ctrl = 16'hFFFF; a_in_data = 32'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      a_state($sformatf("bub%0d", i), 0, 0, 16'h0, 2'd0, 1);
    end

    // SKID=0: out_ready 1,0,1 under continuous input
    b_in_valid = 1; b_in_ctrl = 16'h00F0; b_in_data = 32'h11; b_out_ready = 1;
    step();
    chk("s0.d11", b_out_data, 32'h11);
    b_in_data = 32'h12;
    #1 chk("s0.rdy1", 32'(b_in_ready), 1);
    step();
    chk("s0.d12", b_out_data, 32'h12);
    chk("s0.occ", 32'(b_occ), 1);
    b_out_ready = 0; b_in_data = 32'h13;
    #1 chk("s0.rdy0", 32'(b_in_ready), 0);
    step();
    chk("s0.hold", b_out_data, 32'h12);
    chk("s0.hold_ctrl", 32'(b_out_ctrl), 32'h00F0);
    b_out_ready = 1;
    #1 chk("s0.rdy1b", 32'(b_in_ready), 1);
    step();
    chk("s0.d13", b_out_data, 32'h13);
    b_in_valid = 0;
    step();
    chk("s0.empty_v", 32'(b_out_valid), 0);
    chk("s0.empty_occ", 32'(b_occ), 0);

    // FLUSH_DATA=1 zeroes the payload
    b_in_valid = 1; b_in_data = 32'h55; b_in_ctrl = 16'h00FF; b_out_ready = 0;
    step();
    chk("s0.load55", b_out_data, 32'h55);
    b_flush = 1; b_in_data = 32'h66;
    step();
    b_flush = 0; b_in_valid = 0;
    chk("s0.fl_v", 32'(b_out_valid), 0);
    chk("s0.fl_ctrl", 32'(b_out_ctrl), 0);
    chk("s0.fl_occ", 32'(b_occ), 0);
    chk("s0.fl_data", b_out_data, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
